weight_ram_arbiter: RTL

Shares the single-port weight RAM between two layer controllers: requester 0 is the L1 layer controller and requester 1 is the L2 fully-connected controller. Each requester drives a request and an address.
- Arbitration is round-robin with a burst limit.
- Read data comes back on a shared bus after a fixed RAM latency, tagged with a per-requester valid strobe.
- The block sits between the layer controllers and the weight RAM macro.

---
 rtl/weight_ram_arbiter_if.sv | 40 ++++
 rtl/weight_ram_arbiter.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/weight_ram_arbiter_if.sv
// -----------------------------------------------------------------------------
// weight_ram_arbiter_if
// Bundles the two requester read ports, the weight RAM port and the shared
// read-return bus of weight_ram_arbiter.
//   slave  : arbiter side (takes requests and RAM data, drives grants/RAM/returns)
//   master : environment side (requesters + RAM macro)
// Signals:
//   req0/addr0, gnt0, rvalid0 : requester 0 (L1 layer controller)
//   req1/addr1, gnt1, rvalid1 : requester 1 (L2 FC controller)
//   ram_en, ram_addr, ram_rdata : weight RAM read port
//   rdata : shared read data, busy : arbiter activity flag
// -----------------------------------------------------------------------------
interface weight_ram_arbiter_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 192
);
    logic              req0;
    logic [ADDR_W-1:0] addr0;
    logic              gnt0;
    logic              rvalid0;
    logic              req1;
    logic [ADDR_W-1:0] addr1;
    logic              gnt1;
    logic              rvalid1;
    logic              ram_en;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_rdata;
    logic [DATA_W-1:0] rdata;
    logic              busy;

    modport slave (
        input  req0, addr0, req1, addr1, ram_rdata,
        output gnt0, rvalid0, gnt1, rvalid1, ram_en, ram_addr, rdata, busy
    );

    modport master (
        output req0, addr0, req1, addr1, ram_rdata,
        input  gnt0, rvalid0, gnt1, rvalid1, ram_en, ram_addr, rdata, busy
    );
endinterface

// File: rtl/weight_ram_arbiter.sv
// -----------------------------------------------------------------------------
// weight_ram_arbiter
// Shares the single-port weight RAM between requester 0 (L1 layer controller)
// and requester 1 (L2 FC controller). Default mode is round-robin with a burst
// limit of MAX_BURST consecutive grants while the other side waits. Read data
// returns on a shared bus RD_LAT cycles after the grant, tagged by rvalid0/1.
//
// Build option: define WRAM_ARB_FIXED_PRIO_EN for strict priority to
// requester 0 (burst limit and round-robin history unused).
//
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : weight_ram_arbiter_if.slave (requests, grants, RAM port, returns)
// -----------------------------------------------------------------------------
module weight_ram_arbiter #(
    parameter int ADDR_W    = 9,
    parameter int DATA_W    = 192,
    parameter int RD_LAT    = 1,   // 1..4
    parameter int MAX_BURST = 16   // 2..255
) (
    input  logic                  clk,
    input  logic                  rst,
    weight_ram_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t state;
    logic   gnt0;
    logic   gnt1;

    // Registered return-valid pipe: bit 0 = requester 0, bit 1 = requester 1.
    // Stage RD_LAT lines up with the RAM data for the same grant.
    logic [RD_LAT:1][1:0] vld_pipe;

    // ---------------------------------------------------------------------
    // Grant / RAM drive (combinational from state and current request)
    // ---------------------------------------------------------------------
    assign gnt0 = (state == OWN0) & bus.req0;
    assign gnt1 = (state == OWN1) & bus.req1;

    always_comb begin
        bus.ram_addr = {ADDR_W{1'b0}};
        case (state)
            OWN0:    bus.ram_addr = bus.addr0;
            OWN1:    bus.ram_addr = bus.addr1;
            default: bus.ram_addr = {ADDR_W{1'b0}};
        endcase
    end

    assign bus.gnt0    = gnt0;
    assign bus.gnt1    = gnt1;
    assign bus.ram_en  = gnt0 | gnt1;
    assign bus.rdata   = bus.ram_rdata[DATA_W-1:0];
    assign bus.rvalid0 = vld_pipe[RD_LAT][0];
    assign bus.rvalid1 = vld_pipe[RD_LAT][1];
    assign bus.busy    = (state != IDLE) | (|vld_pipe);

    // ---------------------------------------------------------------------
    // Return-valid shift register; reset drops anything in flight.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[1] <= {gnt1, gnt0};
            for (int i = 2; i <= RD_LAT; i++)
                vld_pipe[i] <= vld_pipe[i-1];
        end
    end

`ifdef WRAM_ARB_FIXED_PRIO_EN
    // ---------------------------------------------------------------------
    // Strict priority: requester 0 pre-empts requester 1 at the next edge;
    // the gnt1 already on the bus this cycle still completes.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req0)      state <= OWN0;
                    else if (bus.req1) state <= OWN1;
                end
                OWN0: begin
                    if (!bus.req0) state <= bus.req1 ? OWN1 : IDLE;
                end
                OWN1: begin
                    if (bus.req0)       state <= OWN0;
                    else if (!bus.req1) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    // ---------------------------------------------------------------------
    // Round-robin with burst limit.
    // burst_cnt counts grants in the current ownership and saturates at
    // MAX_BURST. The switch test uses >= so that an owner that saturated
    // while the other side was idle still yields on the next grant once
    // the other side starts requesting (an exact compare would starve it).
    // ---------------------------------------------------------------------
    localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);
    localparam logic [7:0] BURST_SAT  = 8'(MAX_BURST);

    logic [7:0] burst_cnt;
    logic       last;        // requester that owned the RAM most recently
    logic       burst_done;

    assign burst_done = (burst_cnt >= BURST_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            burst_cnt <= 8'd0;
            last      <= 1'b1;   // requester 0 wins the first tie
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req0 && bus.req1) state <= last ? OWN0 : OWN1;
                    else if (bus.req0)        state <= OWN0;
                    else if (bus.req1)        state <= OWN1;
                end
                // In OWNx, reqx=1 implies gntx=1, so the non-exit path is a grant.
                OWN0: begin
                    if (!bus.req0 || (burst_done && bus.req1)) begin
                        state     <= bus.req1 ? OWN1 : IDLE;
                        last      <= 1'b0;
                        burst_cnt <= 8'd0;
                    end else if (burst_cnt != BURST_SAT) begin
                        burst_cnt <= burst_cnt + 8'd1;
                    end
                end
                OWN1: begin
                    if (!bus.req1 || (burst_done && bus.req0)) begin
                        state     <= bus.req0 ? OWN0 : IDLE;
                        last      <= 1'b1;
                        burst_cnt <= 8'd0;
                    end else if (burst_cnt != BURST_SAT) begin
                        burst_cnt <= burst_cnt + 8'd1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    burst_cnt <= 8'd0;
                end
            endcase
        end
    end
`endif

endmodule
